// File: rtl/mmul_pkg.sv
// Shared helpers for the systolic multiply array: lane depth and log2 math
// used to size the staggered delay lines.
package mmul_pkg;

  // Register depth of lane c in a staggered delay line.
  function automatic int lane_depth(input int c, input int base, input int step);
    return base + c * step;
  endfunction

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Deepest lane of a C-lane line.
  function automatic int d_max(input int c, input int base, input int step);
    return lane_depth(c - 1, base, step);
  endfunction

  // Default geometry of the array operand skew lines.
  localparam int C_DEF    = 4;
  localparam int BASE_DEF = 1;
  localparam int STEP_DEF = 1;
  localparam int D_MAX    = BASE_DEF + (C_DEF - 1) * STEP_DEF;

endpackage

// File: rtl/valid_delay_lane.sv
// Single lane of the skew line: DEPTH registered stages of {valid, data}.
// Handshake: there is no ready; Enable=1 advances every stage by one and
// captures {InValid, In}; Enable=0 holds every stage and drops the input.
module valid_delay_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Enable,
  input  logic         Flush,
  input  logic         InValid,
  input  logic [W-1:0] In,
  output logic         OutValid,
  output logic [W-1:0] Out
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  // Shift chain: reset/flush clear everything, enable shifts, otherwise hold.
  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
    end else if (Enable) begin
      vld_q[0] <= InValid;
      dat_q[0] <= InValid ? In : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign OutValid = vld_q[DEPTH-1];
  assign Out      = dat_q[DEPTH-1];

endmodule

// File: rtl/skew_delay_line.sv
// Multi-lane staggered delay line: lane c delays its word by BASE + c*STEP
// enabled cycles, with valid tracking, stall (Enable=0) and flush.
// Optional macro SKEW_PENDING_EN adds the Pending count of beats accepted
// but not yet retired from the deepest lane.
module skew_delay_line
  import mmul_pkg::*;
#(
  parameter int C    = 4,
  parameter int W    = 32,
  parameter int BASE = 1,
  parameter int STEP = 1
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enable,
  input  logic           Flush,
  input  logic           InValid,
  input  logic [C*W-1:0] In,
  output logic [C-1:0]   OutValid,
  output logic [C*W-1:0] Out
`ifdef SKEW_PENDING_EN
  ,
  output logic [clog2(d_max(C, BASE, STEP) + 1)-1:0] Pending
`endif
);

  // One lane per channel, each deeper than the last by STEP stages.
  for (genvar c = 0; c < C; c++) begin : g_lane
    valid_delay_lane #(
      .DEPTH (lane_depth(c, BASE, STEP)),
      .W     (W)
    ) u_lane (
      .Clock    (Clock),
      .Reset    (Reset),
      .Enable   (Enable),
      .Flush    (Flush),
      .InValid  (InValid),
      .In       (In[c*W +: W]),
      .OutValid (OutValid[c]),
      .Out      (Out[c*W +: W])
    );
  end

`ifdef SKEW_PENDING_EN
  localparam int PW = clog2(d_max(C, BASE, STEP) + 1);

  logic inc, dec;
  assign inc = Enable & InValid;
  assign dec = Enable & OutValid[C-1];

  // In-flight counter: +1 on accept, -1 on retire from the last lane.
  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      Pending <= '0;
    end else if (inc && !dec) begin
      Pending <= Pending + PW'(1);
    end else if (dec && !inc) begin
      Pending <= Pending - PW'(1);
    end
  end
`endif

endmodule
